wb_ledctrl: RTL

WB_LEDCTRL -- requirements
Module: wb_ledctrl

---
 rtl/wb_ledctrl_pkg.sv | 27 ++
 rtl/wb_ledctrl_if.sv | 28 ++
 rtl/wb_ledctrl_gen.sv | 40 ++++
 rtl/wb_ledctrl.sv | 90 +++++++++
 4 files changed

// File: rtl/wb_ledctrl_pkg.sv
// ledctrl_pkg: register offsets, decoded-index width and the byte-lane merge helper shared by the LED controller.
// Contents: IDX_W / reg_idx_t (word index decoded from adr[4:2]), OFF_* byte offsets, idx_of(), lane_merge().
package ledctrl_pkg;

    localparam int IDX_W = 3;

    typedef logic [IDX_W-1:0] reg_idx_t;

    localparam logic [4:0] OFF_LED       = 5'h00;
    localparam logic [4:0] OFF_PWM_EN    = 5'h04;
    localparam logic [4:0] OFF_DUTY      = 5'h08;
    localparam logic [4:0] OFF_BLINK_EN  = 5'h0C;
    localparam logic [4:0] OFF_BLINK_DIV = 5'h10;

    function automatic reg_idx_t idx_of(input logic [4:0] off);
        return off[4:2];
    endfunction

    // Bytes with a clear select bit keep their current contents.
    function automatic logic [31:0] lane_merge(input logic [31:0] cur, input logic [31:0] nxt, input logic [3:0] sel);
        logic [31:0] res;
        for (int b = 0; b < 4; b++)
            res[8*b +: 8] = sel[b] ? nxt[8*b +: 8] : cur[8*b +: 8];
        return res;
    endfunction

endpackage

// File: rtl/wb_ledctrl_if.sv
// wb_ledctrl_if: Wishbone classic bus bundle between a master and the LED controller.
// Signals: adr/dat_i/sel/we/cyc/stb/cti/bte from the master; ack/err/rty/dat_o from the slave.
interface wb_ledctrl_if;

    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i;
    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic [2:0]  wb_cti_i;
    logic [1:0]  wb_bte_i;
    logic        wb_ack_o;
    logic        wb_err_o;
    logic        wb_rty_o;
    logic [31:0] wb_dat_o;

    modport master (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        input  wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );

    modport slave (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i, wb_cti_i, wb_bte_i,
        output wb_ack_o, wb_err_o, wb_rty_o, wb_dat_o
    );

endinterface

// File: rtl/wb_ledctrl_gen.sv
// ledctrl_gen: free-running PWM counter and blink prescaler feeding the LED output mux.
// Ports: clk, rst (async, active high), duty, blink_div, div_clr (restart prescaler) -> pwm_on, blink_ph.
module ledctrl_gen #(
    parameter int PWM_W = 8,
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PWM_W-1:0] duty,
    input  logic [DIV_W-1:0] blink_div,
    input  logic             div_clr,
    output logic             pwm_on,
    output logic             blink_ph
);

    logic [PWM_W-1:0] pwm_cnt;
    logic [DIV_W-1:0] pre;

    assign pwm_on = pwm_cnt < duty;

    // A divider rewrite restarts the period without disturbing the current phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            pre      <= '0;
            blink_ph <= 1'b1;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (div_clr) begin
                pre <= '0;
            end else if (pre == blink_div) begin
                pre      <= '0;
                blink_ph <= ~blink_ph;
            end else begin
                pre <= pre + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/wb_ledctrl.sv
// wb_ledctrl: Wishbone-controlled LED driver with per-LED enable, PWM dimming and blinking.
// Ports: wb_clk, wb_rst (async, active high), wb (slave bus), led_o (registered, 1 = lit).
module wb_ledctrl
    import ledctrl_pkg::*;
#(
    parameter int NUM_LED = 8,
    parameter int PWM_W   = 8,
    parameter int DIV_W   = 24
) (
    input  logic               wb_clk,
    input  logic               wb_rst,
    wb_ledctrl_if.slave        wb,
    output logic [NUM_LED-1:0] led_o
);

    logic               req;
    logic               hit;
    logic               wr;
    reg_idx_t           idx;
    logic [NUM_LED-1:0] led_val;
    logic [NUM_LED-1:0] pwm_en;
    logic [NUM_LED-1:0] blink_en;
    logic [PWM_W-1:0]   duty;
    logic [DIV_W-1:0]   blink_div;
    logic [31:0]        rdata;
    logic               pwm_on;
    logic               blink_ph;
    logic               unused;

    assign idx  = wb.wb_adr_i[4:2];
    // Blocking on our own termination forces an idle cycle between transfers.
    assign req  = wb.wb_cyc_i & wb.wb_stb_i & ~wb.wb_ack_o & ~wb.wb_err_o;
    assign hit  = idx <= idx_of(OFF_BLINK_DIV);
    assign wr   = req & hit & wb.wb_we_i;
    assign wb.wb_rty_o = 1'b0;
    assign unused = ^{wb.wb_cti_i, wb.wb_bte_i, wb.wb_adr_i[31:5], wb.wb_adr_i[1:0]};

    always_comb begin
        rdata = idx == idx_of(OFF_LED)       ? 32'(led_val)   :
                idx == idx_of(OFF_PWM_EN)    ? 32'(pwm_en)    :
                idx == idx_of(OFF_DUTY)      ? 32'(duty)      :
                idx == idx_of(OFF_BLINK_EN)  ? 32'(blink_en)  :
                idx == idx_of(OFF_BLINK_DIV) ? 32'(blink_div) : 32'h0;
    end

    ledctrl_gen #(
        .PWM_W(PWM_W),
        .DIV_W(DIV_W)
    ) u_gen (
        .clk      (wb_clk),
        .rst      (wb_rst),
        .duty     (duty),
        .blink_div(blink_div),
        .div_clr  (wr && idx == idx_of(OFF_BLINK_DIV)),
        .pwm_on   (pwm_on),
        .blink_ph (blink_ph)
    );

    always_ff @(posedge wb_clk or posedge wb_rst) begin
        if (wb_rst) begin
            wb.wb_ack_o <= 1'b0;
            wb.wb_err_o <= 1'b0;
            wb.wb_dat_o <= '0;
            led_val     <= '0;
            pwm_en      <= '0;
            duty        <= '0;
            blink_en    <= '0;
            blink_div   <= '0;
            led_o       <= '0;
        end else begin
            wb.wb_ack_o <= req & hit;
            wb.wb_err_o <= req & ~hit;
            // Writes leave read data alone; errors return zero.
            if (req)
                wb.wb_dat_o <= hit ? (wb.wb_we_i ? wb.wb_dat_o : rdata) : 32'h0;
            if (wr && idx == idx_of(OFF_LED))
                led_val <= NUM_LED'(lane_merge(32'(led_val), wb.wb_dat_i, wb.wb_sel_i));
            if (wr && idx == idx_of(OFF_PWM_EN))
                pwm_en <= NUM_LED'(lane_merge(32'(pwm_en), wb.wb_dat_i, wb.wb_sel_i));
            if (wr && idx == idx_of(OFF_DUTY))
                duty <= PWM_W'(lane_merge(32'(duty), wb.wb_dat_i, wb.wb_sel_i));
            if (wr && idx == idx_of(OFF_BLINK_EN))
                blink_en <= NUM_LED'(lane_merge(32'(blink_en), wb.wb_dat_i, wb.wb_sel_i));
            if (wr && idx == idx_of(OFF_BLINK_DIV))
                blink_div <= DIV_W'(lane_merge(32'(blink_div), wb.wb_dat_i, wb.wb_sel_i));
            led_o <= led_val & (~pwm_en | {NUM_LED{pwm_on}}) & (~blink_en | {NUM_LED{blink_ph}});
        end
    end

endmodule
